perm_sched: RTL and testbench

Sequencer for the Ascon-AEAD128 permutation. It holds the 320-bit state register and steps the round datapath (constant addition, substitution layer, linear layer) through p^12 or p^8. It supplies the round index that selects each round constant. It sits between the AEAD mode FSM, which requests permutations, and the combinational round logic.

---
 rtl/ascon_aead128_pkg.sv | 28 ++
 rtl/ascon_round.sv | 54 +++++
 rtl/perm_sched.sv | 75 +++++++
 tb/tb_perm_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon-AEAD128 types, constants and helpers.
// Used by the permutation sequencer and its round logic.
package ascon_aead128_pkg;

  typedef logic [0:4][63:0] ascon_state;
  typedef logic [3:0] round;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } perm_fsm_t;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 8;

  // Round constant lands in the low byte of x2.
  function automatic ascon_state const_add(
    input ascon_state s,
    input round       r
  );
    ascon_state o;
    o = s;
    o[2][7:0] = s[2][7:0] ^ {4'hf - r, r};
    return o;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round:
// constant addition, 5-bit S-box layer, linear diffusion.
module ascon_round
  import ascon_aead128_pkg::*;
(
  input  round       rnd,
  input  ascon_state din,
  output ascon_state dout
);

  function automatic logic [63:0] ror(
    input logic [63:0] v,
    input int          k
  );
    return (v >> k) | (v << (64 - k));
  endfunction

  ascon_state s;
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // Bitsliced S-box followed by per-word rotations.
  always_comb begin
    s  = const_add(din, rnd);
    x0 = s[0];
    x1 = s[1];
    x2 = s[2];
    x3 = s[3];
    x4 = s[4];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    dout[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    dout[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    dout[2] = x2 ^ ror(x2, 1) ^ ror(x2, 6);
    dout[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    dout[4] = x4 ^ ror(x4, 7) ^ ror(x4, 41);
  end

endmodule

// File: rtl/perm_sched.sv
// Ascon p^12 / p^8 sequencer: holds the state
// register and steps UNROLL chained rounds per clock.
module perm_sched
  import ascon_aead128_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       nr_sel,
  input  ascon_state state_in,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output round       rnd,
  output ascon_state state_out
);

  perm_fsm_t  st, st_nx;
  round       cnt;
  ascon_state sreg;
  ascon_state chain [UNROLL+1];
  logic       last;

  assign chain[0] = sreg;

  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    ascon_round u_rnd (
      .rnd  (cnt + round'(i)),
      .din  (chain[i]),
      .dout (chain[i+1])
    );
  end

  assign last = (int'(cnt) + UNROLL) == ROUNDS_A;

  // Next-state decode.
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:    if (start) st_nx = RUN;
      RUN:     if (last) st_nx = DONE;
      DONE:    st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  // Load on acceptance, advance rounds while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (st == IDLE && start) begin
      sreg <= state_in;
      cnt  <= nr_sel ? round'(ROUNDS_A - ROUNDS_B) : '0;
    end else if (st == RUN) begin
      sreg <= chain[UNROLL];
      cnt  <= last ? '0 : cnt + round'(UNROLL);
    end
  end

  assign ready     = st == IDLE;
  assign busy      = st == RUN;
  assign done      = st == DONE;
  assign rnd       = cnt;
  assign state_out = sreg;

endmodule

// File: tb/tb_perm_sched.sv
// Randomized bench for perm_sched at UNROLL 1, 2 and 4
// against a software Ascon model and cycle timeline.
module tb_perm_sched;
  import ascon_aead128_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start;
  logic       nr_sel;
  ascon_state state_in;

  logic       rdy [3];
  logic       bsy [3];
  logic       dn  [3];
  round       rn  [3];
  ascon_state so  [3];

  perm_sched #(.UNROLL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .nr_sel(nr_sel), .state_in(state_in),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
    .rnd(rn[0]), .state_out(so[0])
  );
  perm_sched #(.UNROLL(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .nr_sel(nr_sel), .state_in(state_in),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
    .rnd(rn[1]), .state_out(so[1])
  );
  perm_sched #(.UNROLL(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start[2]),
    .nr_sel(nr_sel), .state_in(state_in),
    .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]),
    .rnd(rn[2]), .state_out(so[2])
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic int u_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  function automatic logic [63:0] ror(
    input logic [63:0] v,
    input int          k
  );
    return (v >> k) | (v << (64 - k));
  endfunction

  // Reference Ascon permutation, last n rounds.
  function automatic ascon_state perm(
    input ascon_state s,
    input int         n
  );
    logic [63:0] x [5];
    logic [63:0] t [5];
    ascon_state  o;
    for (int i = 0; i < 5; i++) x[i] = s[i];
    for (int r = 12 - n; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int i = 0; i < 5; i++)
        t[i] = ~x[i] & x[(i + 1) % 5];
      for (int i = 0; i < 5; i++)
        x[i] ^= t[(i + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2];
      x[2] = ~x[2];
      x[0] ^= ror(x[0], 19) ^ ror(x[0], 28);
      x[1] ^= ror(x[1], 61) ^ ror(x[1], 39);
      x[2] ^= ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] ^= ror(x[3], 10) ^ ror(x[3], 17);
      x[4] ^= ror(x[4], 7)  ^ ror(x[4], 41);
    end
    for (int i = 0; i < 5; i++) o[i] = x[i];
    return o;
  endfunction

  function automatic ascon_state rand_st();
    ascon_state s;
    for (int i = 0; i < 5; i++)
      s[i] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(
    input string        nm,
    input int           k,
    input logic [319:0] a,
    input logic [319:0] e
  );
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s u%0d got %h want %h",
               nm, u_of(k), a, e);
    end
  endtask

  // Timeline model: cycles since acceptance (0 = idle).
  int         m_cyc [3] = '{0, 0, 0};
  int         m_n   [3] = '{12, 12, 12};
  ascon_state m_res [3] = '{'0, '0, '0};

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_cyc[k] = 0;
        m_res[k] = '0;
      end else if (m_cyc[k] == 0) begin
        if (start[k]) begin
          m_n[k]   = nr_sel ? 8 : 12;
          m_res[k] = perm(state_in, m_n[k]);
          m_cyc[k] = 1;
        end
      end else if (m_cyc[k] == m_n[k] / u_of(k) + 1) begin
        m_cyc[k] = 0;
      end else begin
        m_cyc[k]++;
      end
    end
  end

  // Per-cycle comparison against the timeline model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        int c, n, u;
        c = m_cyc[k];
        n = m_n[k];
        u = u_of(k);
        chk("ready", k, 320'(rdy[k]), 320'(c == 0));
        chk("busy", k, 320'(bsy[k]),
            320'(c >= 1 && c <= n / u));
        chk("done", k, 320'(dn[k]),
            320'(c == n / u + 1));
        if (c >= 1 && c <= n / u)
          chk("rnd", k, 320'(rn[k]),
              320'(12 - n + (c - 1) * u));
        else
          chk("state_out", k, so[k], m_res[k]);
      end
    end
  end

  // Single request to all three, measuring done latency.
  task automatic lat(
    input bit         nr,
    input ascon_state s,
    input int         e0,
    input int         e1,
    input int         e2
  );
    int first [3];
    int exp_l [3];
    exp_l = '{e0, e1, e2};
    first = '{0, 0, 0};
    @(negedge clk);
    start    = 3'b111;
    nr_sel   = nr;
    state_in = s;
    @(negedge clk);
    start    = 3'b000;
    for (int c = 1; c <= 20; c++) begin
      for (int k = 0; k < 3; k++)
        if (dn[k] && first[k] == 0) first[k] = c;
      nr_sel   = 1'($urandom);
      state_in = rand_st();
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++)
      chk("latency", k, 320'(first[k]), 320'(exp_l[k]));
  endtask

  ascon_state kat;

  initial begin
    rst_n    = 1'b0;
    start    = 3'b000;
    nr_sel   = 1'b0;
    state_in = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("rst_ready", k, 320'(rdy[k]), 320'(1));
        chk("rst_done", k, 320'(dn[k]), 320'(0));
        chk("rst_rnd", k, 320'(rn[k]), 320'(0));
        chk("rst_state", k, so[k], 320'(0));
      end
    end

    kat[0] = 64'h00001000808c0001;
    kat[1] = 64'h0001020304050607;
    kat[2] = 64'h08090a0b0c0d0e0f;
    kat[3] = 64'h0001020304050607;
    kat[4] = 64'h08090a0b0c0d0e0f;
    lat(1'b0, kat, 13, 7, 4);
    lat(1'b1, rand_st(), 9, 5, 3);

    start = 3'b111;
    repeat (90) begin
      @(negedge clk);
      state_in = rand_st();
      if (m_cyc[0] == 0) nr_sel = ~nr_sel;
    end
    start = 3'b000;
    repeat (20) @(negedge clk);

    start    = 3'b111;
    nr_sel   = 1'b0;
    state_in = rand_st();
    @(negedge clk);
    start = 3'b000;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_state", k, so[k], 320'(0));
      chk("midrst_ready", k, 320'(rdy[k]), 320'(1));
      chk("midrst_done", k, 320'(dn[k]), 320'(0));
    end
    lat(1'b0, rand_st(), 13, 7, 4);

    repeat (600) begin
      @(negedge clk);
      start    = 3'($urandom);
      nr_sel   = 1'($urandom);
      state_in = rand_st();
      rst_n    = $urandom_range(0, 79) != 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 3'b000;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
